scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
- Parametrised, registered successor to the 1-to-2 enable decoder: SEL_W-bit select into a 2^SEL_W one-hot output.
- Adds three modes:
  - direct decode with 1-cycle registered latency;
  - single-pass scan, where an internal sequencer walks every output with a programmable dwell;
  - continuous wrap-around scan.
- Used as a row/strobe driver feeding multi-channel select logic.

Parameters:
- SEL_W, 2, select width; output count N = 2^SEL_W.
- DWELL_W, 4, dwell counter width; each scanned output is held dwell+1 cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  global enable; low forces outputs to zero and aborts any scan
- mode  input  2  00 direct, 01 single scan, 10 continuous scan, 11 treated as direct
- sel  input  SEL_W  direct-mode select
- sel_valid  input  1  direct-mode select strobe
- sel_ready  output  1  high when the block accepts sel_valid (state IDLE, enable=1, mode direct)
- start  input  1  scan start pulse
- dwell  input  DWELL_W  dwell count, sampled on accepted start
- dec_out  output  N  registered one-hot output, or zero
- cur_idx  output  SEL_W  index currently driven
- busy  output  1  high in SCAN
- done  output  1  one-cycle pulse at the end of a single-pass scan

Behaviour:
- Reset (async, rst_n=0): state=IDLE, dec_out=0, cur_idx=0, busy=0, done=0, sel_ready=0, dwell counter=0, latched mode=00.
- States: IDLE, SCAN, DONE.
- IDLE, direct mode:
  - sel_valid=1 with enable=1: next cycle dec_out = 1<<sel and cur_idx = sel. Latency is exactly 1 cycle.
  - The output holds until the next accepted sel_valid.
  - sel_valid=0 leaves dec_out unchanged.
- IDLE, scan mode:
  - start=1 with enable=1 and mode 01/10: latch mode and dwell, go to SCAN.
  - Next cycle: dec_out=1<<0, cur_idx=0, dwell counter=dwell, busy=1.
  - sel_valid is ignored in scan modes.
- SCAN:
  - Each cycle the dwell counter decrements. At counter=0 with cur_idx<N-1: cur_idx++, dec_out shifts left by 1, counter reloads from latched dwell.
  - At counter=0 with cur_idx=N-1:
    - latched mode 01: go to DONE; dec_out=0, busy=0, done=1 for one cycle.
    - latched mode 10: wrap to cur_idx=0, dec_out=1, reload counter, stay in SCAN.
- DONE: lasts one cycle, then IDLE with done=0, dec_out=0, cur_idx=0.
- Single-pass duration: from start sampled to done high is N*(dwell+1)+1 cycles.
- enable=0, any state: next cycle dec_out=0, busy=0, state=IDLE, done stays 0. An aborted scan never pulses done.
- Changes to mode, dwell or start while in SCAN or DONE are ignored. Continuous scan ends only via enable=0.
- Simultaneous start and sel_valid in IDLE: mode decides. Direct honours sel_valid; scan honours start.
- dwell=0: each output is held exactly 1 cycle.
- Invariant: dec_out is always one-hot or all-zero, never multi-hot.
- sel_ready is combinational from state, enable and mode; it never depends on sel_valid.

Decomposition:
- Package scan_decoder_pkg:
  - state enum (IDLE, SCAN, DONE);
  - mode constants MODE_DIRECT=2'b00, MODE_SINGLE=2'b01, MODE_CONT=2'b10.
- One sub-module, onehot_dec (parameter SEL_W): purely combinational SEL_W to 2^SEL_W decode with enable, the generalised form of the 1-to-2 decoder. It is instanced once to generate dec_out from the next-index value.
- The top level holds the FSM, dwell counter and output registers.

Test Plan:
- Reset, then direct mode: enable=1, mode=00, sel=2, sel_valid=1 for 1 cycle -> next cycle dec_out=4'b0100, cur_idx=2; holds 5 cycles after sel_valid drops. sel=3 -> 4'b1000 one cycle later.
- Direct mode, enable=0 for 1 cycle -> dec_out=4'b0000 the next cycle; sel_ready=0 while enable=0.
- Single scan: mode=01, dwell=1, start pulse -> dec_out sequence 0001,0001,0010,0010,0100,0100,1000,1000, then done=1 with dec_out=0000 for 1 cycle, then IDLE; busy high for exactly 8 cycles.
- Continuous scan: mode=10, dwell=0 -> 0001,0010,0100,1000,0001 wrap; done never asserts; a start pulse mid-scan causes no restart.
- Abort: mode=01, dwell=3, drop enable while cur_idx=1 -> next cycle dec_out=0, busy=0, done=0; re-enable plus start restarts at index 0.
- Async reset: assert rst_n=0 between clock edges during SCAN -> dec_out, busy, done and cur_idx go to 0 immediately without a clock edge; after release the block is in IDLE.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// Shared types and mode encodings for the scan_decoder row/strobe driver.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_CONT   = 2'b10;

    // Mode 11 is deliberately not a scan mode, so it behaves as direct decode.
    function automatic logic is_scan_mode(input logic [1:0] m);
        return (m == MODE_SINGLE) || (m == MODE_CONT);
    endfunction

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational SEL_W to 2^SEL_W one-hot decoder with enable; the generalised
// form of the original 1-to-2 enable decoder.
module onehot_dec #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic                  en,
    output logic [(1<<SEL_W)-1:0] dec
);

    always_comb begin
        dec = '0;
        if (en) begin
            dec[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct, single-pass scan and continuous scan
// modes; drives row/strobe selects for downstream multi-channel logic.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  sel_valid,
    output logic                  sel_ready,
    input  logic                  start,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(1<<SEL_W)-1:0] dec_out,
    output logic [SEL_W-1:0]      cur_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int N = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = '1;

    state_e             state_q;
    state_e             state_nxt;
    logic [1:0]         mode_q;
    logic [1:0]         mode_nxt;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_nxt;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_nxt;
    logic [SEL_W-1:0]   idx_nxt;
    logic               out_en_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [N-1:0]       dec_nxt;

    assign sel_ready = (state_q == IDLE) && enable && !is_scan_mode(mode);

    // dec_out is always either zero or the one-hot of cur_idx, so a hold is
    // expressed as re-decoding cur_idx with the enable taken from |dec_out.
    always_comb begin
        state_nxt  = state_q;
        mode_nxt   = mode_q;
        dwell_nxt  = dwell_q;
        cnt_nxt    = cnt_q;
        idx_nxt    = cur_idx;
        out_en_nxt = |dec_out;
        busy_nxt   = busy;
        done_nxt   = 1'b0;

        if (!enable) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            idx_nxt    = '0;
            out_en_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_scan_mode(mode)) begin
                        if (start) begin
                            state_nxt  = SCAN;
                            mode_nxt   = mode;
                            dwell_nxt  = dwell;
                            cnt_nxt    = dwell;
                            idx_nxt    = '0;
                            out_en_nxt = 1'b1;
                            busy_nxt   = 1'b1;
                        end
                    end else if (sel_valid) begin
                        idx_nxt    = sel;
                        out_en_nxt = 1'b1;
                    end
                end
                SCAN: begin
                    if (cnt_q != '0) begin
                        cnt_nxt = cnt_q - 1'b1;
                    end else if (cur_idx != LAST_IDX) begin
                        idx_nxt = cur_idx + 1'b1;
                        cnt_nxt = dwell_q;
                    end else if (mode_q == MODE_CONT) begin
                        idx_nxt = '0;
                        cnt_nxt = dwell_q;
                    end else begin
                        state_nxt  = DONE;
                        idx_nxt    = '0;
                        out_en_nxt = 1'b0;
                        busy_nxt   = 1'b0;
                        done_nxt   = 1'b1;
                    end
                end
                DONE: begin
                    state_nxt  = IDLE;
                    idx_nxt    = '0;
                    out_en_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                end
                default: begin
                    state_nxt  = IDLE;
                    idx_nxt    = '0;
                    out_en_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                end
            endcase
        end
    end

    onehot_dec #(
        .SEL_W(SEL_W)
    ) u_dec (
        .sel(idx_nxt),
        .en (out_en_nxt),
        .dec(dec_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_DIRECT;
            dwell_q <= '0;
            cnt_q   <= '0;
            cur_idx <= '0;
            dec_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            mode_q  <= mode_nxt;
            dwell_q <= dwell_nxt;
            cnt_q   <= cnt_nxt;
            cur_idx <= idx_nxt;
            dec_out <= dec_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(dec_out));

endmodule

// File: tb/tb_scan_decoder.sv
// Directed testbench for scan_decoder (SEL_W=2, DWELL_W=4).
module tb_scan_decoder;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode;
    logic [1:0] sel;
    logic       sel_valid;
    logic       sel_ready;
    logic       start;
    logic [3:0] dwell;
    logic [3:0] dec_out;
    logic [1:0] cur_idx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    scan_decoder #(.SEL_W(2), .DWELL_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .mode     (mode),
        .sel      (sel),
        .sel_valid(sel_valid),
        .sel_ready(sel_ready),
        .start    (start),
        .dwell    (dwell),
        .dec_out  (dec_out),
        .cur_idx  (cur_idx),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; mode = 2'b00; sel = '0;
        sel_valid = 1'b0; start = 1'b0; dwell = '0;
        #22;
        checks++; if (dec_out !== 4'b0000) begin errors++; $display("FAIL reset_dec_out got %b exp 0000", dec_out); end
        checks++; if (cur_idx !== 2'd0) begin errors++; $display("FAIL reset_cur_idx got %0d exp 0", cur_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (sel_ready !== 1'b0) begin errors++; $display("FAIL reset_sel_ready got %b exp 0", sel_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_direct();
        enable = 1'b1; mode = 2'b00;
        #1;
        checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL direct_sel_ready got %b exp 1", sel_ready); end
        sel = 2'd2; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0; sel = 2'd0;
        checks++; if (dec_out !== 4'b0100) begin errors++; $display("FAIL direct_sel2 got %b exp 0100", dec_out); end
        checks++; if (cur_idx !== 2'd2) begin errors++; $display("FAIL direct_idx2 got %0d exp 2", cur_idx); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (dec_out !== 4'b0100) begin errors++; $display("FAIL direct_hold%0d got %b exp 0100", i, dec_out); end
        end
        sel = 2'd3; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        checks++; if (dec_out !== 4'b1000) begin errors++; $display("FAIL direct_sel3 got %b exp 1000", dec_out); end
        checks++; if (cur_idx !== 2'd3) begin errors++; $display("FAIL direct_idx3 got %0d exp 3", cur_idx); end
        // mode 11 behaves as direct
        mode = 2'b11; sel = 2'd1; sel_valid = 1'b1;
        #1;
        checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL mode11_sel_ready got %b exp 1", sel_ready); end
        tick();
        sel_valid = 1'b0;
        checks++; if (dec_out !== 4'b0010) begin errors++; $display("FAIL mode11_sel1 got %b exp 0010", dec_out); end
        // direct mode honours sel_valid over a simultaneous start
        mode = 2'b00; sel = 2'd0; sel_valid = 1'b1; start = 1'b1;
        tick();
        sel_valid = 1'b0; start = 1'b0;
        checks++; if (dec_out !== 4'b0001) begin errors++; $display("FAIL direct_vs_start got %b exp 0001", dec_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL direct_vs_start_busy got %b exp 0", busy); end
    endtask

    task automatic test_enable_low();
        enable = 1'b0;
        #1;
        checks++; if (sel_ready !== 1'b0) begin errors++; $display("FAIL en_low_sel_ready got %b exp 0", sel_ready); end
        tick();
        checks++; if (dec_out !== 4'b0000) begin errors++; $display("FAIL en_low_dec_out got %b exp 0000", dec_out); end
        enable = 1'b1;
        #1;
        checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL en_high_sel_ready got %b exp 1", sel_ready); end
        tick();
    endtask

    task automatic test_single_scan();
        logic [3:0] exp_seq [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                    4'b0100, 4'b0100, 4'b1000, 4'b1000};
        int busy_cycles = 0;
        mode = 2'b01; dwell = 4'd1; start = 1'b1;
        sel = 2'd3; sel_valid = 1'b1;
        #1;
        checks++; if (sel_ready !== 1'b0) begin errors++; $display("FAIL single_sel_ready got %b exp 0", sel_ready); end
        tick();
        start = 1'b0; sel_valid = 1'b0; dwell = 4'd7;
        for (int i = 0; i < 8; i++) begin
            checks++; if (dec_out !== exp_seq[i]) begin errors++; $display("FAIL single_seq%0d got %b exp %b", i, dec_out, exp_seq[i]); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_early_done%0d got %b exp 0", i, done); end
            if (busy === 1'b1) busy_cycles++;
            tick();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", done); end
        checks++; if (dec_out !== 4'b0000) begin errors++; $display("FAIL single_done_dec got %b exp 0000", dec_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done_busy got %b exp 0", busy); end
        checks++; if (busy_cycles !== 8) begin errors++; $display("FAIL single_busy_len got %0d exp 8", busy_cycles); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b exp 0", done); end
        checks++; if (dec_out !== 4'b0000) begin errors++; $display("FAIL single_idle_dec got %b exp 0000", dec_out); end
        checks++; if (cur_idx !== 2'd0) begin errors++; $display("FAIL single_idle_idx got %0d exp 0", cur_idx); end
        mode = 2'b00;
        #1;
        checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL single_back_idle got %b exp 1", sel_ready); end
    endtask

    task automatic test_continuous();
        logic [3:0] exp_seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        mode = 2'b10; dwell = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            checks++; if (dec_out !== exp_seq[i % 4]) begin errors++; $display("FAIL cont_seq%0d got %b exp %b", i, dec_out, exp_seq[i % 4]); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL cont_done%0d got %b exp 0", i, done); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy%0d got %b exp 1", i, busy); end
            // a start pulse plus mode/dwell changes mid-scan must be ignored
            start = (i == 5); mode = (i >= 5) ? 2'b01 : 2'b10; dwell = (i >= 5) ? 4'd5 : 4'd0;
            tick();
        end
        start = 1'b0;
        enable = 1'b0;
        tick();
        checks++; if (dec_out !== 4'b0000) begin errors++; $display("FAIL cont_stop_dec got %b exp 0000", dec_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cont_stop_done got %b exp 0", done); end
        enable = 1'b1;
        tick();
    endtask

    task automatic test_abort();
        mode = 2'b01; dwell = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (dec_out !== 4'b0001) begin errors++; $display("FAIL abort_first got %b exp 0001", dec_out); end
        repeat (4) tick();
        checks++; if (cur_idx !== 2'd1) begin errors++; $display("FAIL abort_idx got %0d exp 1", cur_idx); end
        checks++; if (dec_out !== 4'b0010) begin errors++; $display("FAIL abort_dec_pre got %b exp 0010", dec_out); end
        enable = 1'b0;
        tick();
        checks++; if (dec_out !== 4'b0000) begin errors++; $display("FAIL abort_dec got %b exp 0000", dec_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done); end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done%0d got %b exp 0", i, done); end
        end
        enable = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (dec_out !== 4'b0001) begin errors++; $display("FAIL restart_dec got %b exp 0001", dec_out); end
        checks++; if (cur_idx !== 2'd0) begin errors++; $display("FAIL restart_idx got %0d exp 0", cur_idx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b exp 1", busy); end
    endtask

    task automatic test_async_reset();
        repeat (5) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got %b exp 1", busy); end
        checks++; if (cur_idx !== 2'd1) begin errors++; $display("FAIL areset_pre_idx got %0d exp 1", cur_idx); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dec_out !== 4'b0000) begin errors++; $display("FAIL areset_dec got %b exp 0000", dec_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done got %b exp 0", done); end
        checks++; if (cur_idx !== 2'd0) begin errors++; $display("FAIL areset_idx got %0d exp 0", cur_idx); end
        mode = 2'b00;
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL areset_idle got %b exp 1", sel_ready); end
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_post_busy got %b exp 0", busy); end
        checks++; if (dec_out !== 4'b0000) begin errors++; $display("FAIL areset_post_dec got %b exp 0000", dec_out); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_direct();
        test_enable_low();
        test_single_scan();
        test_continuous();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
